// File: rtl/counter_seq_pkg.sv
// Shared command encodings, sequencer states and the default terminal count
// for the counter sequencer slice.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        CMD_START  = 2'b00,
        CMD_PAUSE  = 2'b01,
        CMD_RESUME = 2'b10,
        CMD_STOP   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam int unsigned MAX_DEFAULT = 99;

endpackage

// File: rtl/counter_core.sv
// Modulo-(limit+1) up-counter; wrap pulses the cycle after limit->0,
// coincident with the count reading zero.
module counter_core #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == limit) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer around counter_core: start/pause/resume/stop,
// tick prescaler, pass counting and end-of-run done pulse.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MAX_DEFAULT = counter_seq_pkg::MAX_DEFAULT,
    parameter int unsigned DIV_W       = 4,
    parameter int unsigned PASS_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd,
    input  logic [CNT_W-1:0]  i_limit,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [PASS_W-1:0] i_repeat,
    output logic [CNT_W-1:0]  o_counter,
    output logic [PASS_W-1:0] o_pass,
    output logic              o_busy,
    output logic              o_paused,
    output logic              o_wrap,
    output logic              o_done,
    output logic              o_cmd_err
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [PASS_W-1:0] rep_q, rep_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              err_q, err_d;
    logic              tick, clr, accept;
    logic [PASS_W-1:0] pass_inc;
    logic [CNT_W-1:0]  count;
    cmd_e              cmd;

    assign cmd         = cmd_e'(i_cmd);
    assign o_cmd_ready = (state_q != ST_DONE);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign pass_inc    = pass_q + PASS_W'(1);

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        div_d   = div_q;
        rep_d   = rep_q;
        presc_d = presc_q;
        pass_d  = pass_q;
        err_d   = 1'b0;
        tick    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd == CMD_START) begin
                        limit_d = (i_limit == '0) ? CNT_W'(MAX_DEFAULT) : i_limit;
                        div_d   = i_div;
                        rep_d   = i_repeat;
                        presc_d = '0;
                        pass_d  = '0;
                        clr     = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // An accepted PAUSE/STOP suppresses this cycle's tick entirely.
                if (accept && cmd == CMD_PAUSE) begin
                    state_d = ST_PAUSE;
                end else if (accept && cmd == CMD_STOP) begin
                    presc_d = '0;
                    pass_d  = '0;
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    err_d = accept;
                    if (presc_q == div_q) begin
                        presc_d = '0;
                        tick    = 1'b1;
                        if (count == limit_q) begin
                            pass_d = pass_inc;
                            if (rep_q != '0 && pass_inc == rep_q) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (accept && cmd == CMD_RESUME) begin
                    state_d = ST_RUN;
                end else if (accept && cmd == CMD_STOP) begin
                    presc_d = '0;
                    pass_d  = '0;
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    err_d = accept;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            div_q   <= '0;
            rep_q   <= '0;
            presc_q <= '0;
            pass_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            div_q   <= div_d;
            rep_q   <= rep_d;
            presc_q <= presc_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    counter_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .clr   (clr),
        .limit (limit_q),
        .count (count),
        .wrap  (o_wrap)
    );

    assign o_counter = count;
    assign o_pass    = pass_q;
    assign o_busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign o_paused  = (state_q == ST_PAUSE);
    assign o_done    = (state_q == ST_DONE);
    assign o_cmd_err = err_q;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven controller that sequences a modulo-N up-counter: start, pause, resume and stop, with a programmable limit, tick prescaler and pass count.
Sits between a host/control FSM and the counter datapath.
Reports live count, per-pass wrap pulses and a single end-of-run done pulse.
Replaces free-running counters wherever the count must be started, bounded and stopped on command.

Parameters:
CNT_W, 8, counter/limit width.
MAX_DEFAULT, 99, limit used when i_limit==0 at START.
DIV_W, 4, prescaler divide-field width.
PASS_W, 4, pass counter / repeat-field width.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
i_cmd_valid  in  1  command present.
o_cmd_ready  out  1  command can be accepted this cycle.
i_cmd  in  2  00 START, 01 PAUSE, 10 RESUME, 11 STOP.
i_limit  in  CNT_W  terminal count, sampled on accepted START.
i_div  in  DIV_W  counter advances once every i_div+1 cycles, sampled on START.
i_repeat  in  PASS_W  passes to run, 0 = continuous, sampled on START.
o_counter  out  CNT_W  current count.
o_pass  out  PASS_W  completed passes this run.
o_busy  out  1  high in RUN or PAUSE.
o_paused  out  1  high in PAUSE.
o_wrap  out  1  one-cycle pulse on each limit->0 wrap.
o_done  out  1  one-cycle pulse at end of final pass.
o_cmd_err  out  1  one-cycle pulse when an accepted command is illegal for the current state.

Behaviour:
- Reset:
  - reset=1 at an edge puts state in IDLE and clears all outputs to 0, except o_cmd_ready=1.
  - Reset mid-run aborts immediately; no done pulse.
- Handshake:
  - A command is accepted on an edge where i_cmd_valid & o_cmd_ready.
  - o_cmd_ready=1 in IDLE/RUN/PAUSE and 0 in DONE.
  - Illegal commands are accepted, dropped, and pulse o_cmd_err the next cycle.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: START latches the effective limit (i_limit, or MAX_DEFAULT if 0), div and repeat; clears counter, prescaler and pass; next state RUN. PAUSE, RESUME and STOP are illegal.
  - RUN: PAUSE goes to PAUSE; STOP goes to IDLE; START and RESUME are illegal.
  - PAUSE: RESUME goes to RUN; STOP goes to IDLE; START and PAUSE are illegal. Counter and prescaler are frozen.
  - DONE: lasts exactly one cycle, with o_done=1; then IDLE.
- Counting in RUN:
  - The prescaler counts 0..div; a tick occurs on the cycle prescaler==div, then the prescaler returns to 0.
  - On a tick: counter+1. If counter==limit, counter becomes 0, o_wrap=1 on the next cycle (coincident with o_counter==0), and pass+1.
  - Pass wraps mod 2^PASS_W when repeat==0.
  - If repeat!=0 and the new pass==repeat, next state is DONE; o_done and the final o_wrap coincide; counter stays 0.
  - If the limit is set above 2^CNT_W-1, no truncation issue arises, because the limit is CNT_W wide.
- Latency:
  - With div=0, the first increment is 1 cycle after entering RUN.
  - One pass takes (limit+1)*(div+1) cycles.
- Simultaneous events:
  - STOP or PAUSE in the same cycle as a tick: the command wins and the tick is discarded (counter unchanged).
  - STOP: o_counter and o_pass are cleared to 0 on entering IDLE; no o_done.
  - After DONE: o_counter=0, and o_pass holds the final value until the next START.

Decomposition:
- Package counter_seq_pkg holds:
  - command encodings CMD_START/PAUSE/RESUME/STOP;
  - the state enum IDLE/RUN/PAUSE/DONE;
  - the default MAX_DEFAULT.
- Sub-module counter_core:
  - mod-(limit+1) counter with inputs en (tick), clr and limit;
  - outputs count and wrap.
- The sequencer FSM, prescaler and pass counter live in the top level.

Test Plan:
- START, limit=3, div=0, repeat=1 → o_counter 0,1,2,3,0 on consecutive cycles; o_wrap and o_done high together for 1 cycle; then IDLE, o_busy=0.
- START, limit=0, div=0, repeat=1 → effective limit 99; o_done exactly 100 cycles after RUN entry.
- START, limit=2, div=3, repeat=2 → each count held 4 cycles; 2 wrap pulses 12 cycles apart; o_pass=2; single o_done.
- Run limit=9; PAUSE at count 5 for 10 cycles; then RESUME → o_counter stays 5 and o_paused=1 while paused; counting resumes 6,7,…
- STOP in the same cycle as a tick at count 4 → next cycle IDLE, o_counter=0, no o_done. PAUSE issued in IDLE → o_cmd_err pulse, state unchanged.
- Assert reset mid-run at count 7, repeat=0 → next edge all outputs 0, o_cmd_ready=1. A new START then runs normally from 0.
